mmio_interconnect: RTL
======================

# mmio_interconnect

Parametrised CPU data-bus interconnect: decodes each data-memory request against NUM_REGIONS base/mask windows, steers write masks and select strobes to the matching device, and returns read data after that region's configured read latency. It sits between the CPU data port and the chipset devices (BIOS, RAM, VRAM, MMIO registers). Unlike a fixed one-cycle decoder, it adds a ready/valid handshake, per-region multi-cycle latency, and bus-error reporting for unmapped accesses.

## Interface
- NUM_REGIONS, 4: number of decode windows (1..16).
- REGION_BASE, all '0: packed NUM_REGIONS x 32; window i base address.
- REGION_MASK, all '0: packed NUM_REGIONS x 32; window i matches when (addr & MASK[i]) == BASE[i].
- REGION_LATENCY, all 1: packed NUM_REGIONS x 4; window i read latency L in cycles (1..15; 0 is treated as 1).
- clk_i  in  1  CPU clock.
- reset_i  in  1  reset; synchronous, active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  interconnect accepts a request this cycle.
- req_addr_i  in  32  byte address.
- req_write_data_i  in  32  write data.
- req_write_mask_i  in  4  byte write enables; 4'b0000 means read.
- dev_addr_o  out  32  req_addr_i, passed through.
- dev_write_data_o  out  32  req_write_data_i, passed through.
- dev_sel_o  out  NUM_REGIONS  one-hot; accepted access to window i.
- dev_write_mask_o  out  NUM_REGIONS x 4  req_write_mask_i gated to the selected window.
- dev_read_data_i  in  NUM_REGIONS x 32  device read data.
- resp_valid_o  out  1  read response cycle.
- resp_data_o  out  32  read data; valid only when resp_valid_o is high.
- resp_err_o  out  1  the response is for an unmapped read.
- err_count_o  out  16  saturating count of unmapped accesses.
- err_addr_o  out  32  address of the most recent unmapped access.

## Operation
- Decode: the lowest-index matching window wins; no match means unmapped.
- Accept: a request is accepted in a cycle where req_valid_i and req_ready_o are both high.
- dev_sel_o and dev_write_mask_o are combinational and asserted only in the acceptance cycle.
- Devices capture address and select on the acceptance edge; the interconnect does not hold them afterwards.
- Write, mapped: completes at the acceptance edge; no response is generated; req_ready_o stays high.
- Write, unmapped: dropped (all masks 0); err_count_o and err_addr_o update; no response.
- Read, mapped: the window index is registered at acceptance, and the transaction state is WAIT with counter = L-1.
- The response cycle is L cycles after the acceptance cycle.
- In the response cycle, resp_data_o = dev_read_data_i[window] (combinational mux on the registered index) and resp_valid_o = 1.
- Read, unmapped: behaves as L=1, with resp_data_o = 0 and resp_err_o = 1; the error registers update.
- States:
  - IDLE: req_ready_o = 1.
  - WAIT: counter > 0, req_ready_o = 0, decrement each cycle; at 0, go to RESP.
  - RESP: resp_valid_o = 1 and req_ready_o = 1; a new request may be accepted in the same cycle. If none is accepted, go to IDLE.
- For L=1, acceptance goes directly to RESP. Back-to-back L=1 reads therefore give one response per cycle.
- err_count_o saturates at 16'hFFFF; err_addr_o still updates when the count is saturated.

## Timing
- Outputs during reset_i: req_ready_o = 0, resp_valid_o = 0, resp_err_o = 0, resp_data_o = 0, dev_sel_o = 0, dev_write_mask_o = 0, err_count_o = 0, err_addr_o = 0. State returns to IDLE.
- The first acceptance is possible in the cycle after reset_i deasserts.
- Reset during WAIT or RESP aborts the transaction; no response is issued afterwards.
- Read latency: acceptance cycle t gives resp_valid_o in cycle t+L, for exactly one cycle.
- Maximum read throughput: one request per L cycles.
- Write throughput: one per cycle, including while in RESP.
- req_ready_o is registered-state based and never depends combinationally on req_valid_i.
- Response-cycle acceptance: if a request is accepted in the RESP cycle of the prior read, the old response is still delivered in that cycle, and the new transaction's index register updates at the same edge.

## Test plan
- Regions {0x0000_0000/0xF000_0000 L1, 0x1000_0000/0xF000_0000 L3}: read 0x1000_0010 at cycle t -> resp_valid_o only in cycle t+3; req_ready_o low in t+1..t+2; data = dev_read_data_i[1].
- Three back-to-back L=1 reads to region 0 -> resp_valid_o high three consecutive cycles; each response carries its own data.
- Write 0x1000_0004, mask 4'b0011 -> dev_write_mask_o[1] = 4'b0011 and all other windows 0, only in the acceptance cycle; no resp_valid_o.
- Read 0x3000_0000 (unmapped) -> next cycle resp_valid_o = 1, resp_err_o = 1, resp_data_o = 0; err_count_o = 1; err_addr_o = 0x3000_0000.
- Overlapping windows 0 and 1 both matching 0x0000_0100 -> only dev_sel_o[0] is asserted.
- reset_i asserted in the second WAIT cycle of an L=3 read -> no resp_valid_o; outputs take their reset values; err_count_o = 0; a new read accepted after reset completes normally.

Source files
------------

// File: rtl/mmio_interconnect.sv
// CPU data-bus interconnect: base/mask window decode, per-window select and write-mask
// steering, ready/valid request handshake, per-window read latency and unmapped-access errors.
module mmio_interconnect #(
    parameter int                          NUM_REGIONS    = 4,
    parameter logic [NUM_REGIONS*32-1:0]   REGION_BASE    = '0,
    parameter logic [NUM_REGIONS*32-1:0]   REGION_MASK    = '0,
    parameter logic [NUM_REGIONS*4-1:0]    REGION_LATENCY = {NUM_REGIONS{4'd1}}
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [31:0]                 req_addr_i,
    input  logic [31:0]                 req_write_data_i,
    input  logic [3:0]                  req_write_mask_i,
    output logic [31:0]                 dev_addr_o,
    output logic [31:0]                 dev_write_data_o,
    output logic [NUM_REGIONS-1:0]      dev_sel_o,
    output logic [NUM_REGIONS*4-1:0]    dev_write_mask_o,
    input  logic [NUM_REGIONS*32-1:0]   dev_read_data_i,
    output logic                        resp_valid_o,
    output logic [31:0]                 resp_data_o,
    output logic                        resp_err_o,
    output logic [15:0]                 err_count_o,
    output logic [31:0]                 err_addr_o
);

    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [3:0]         count_reg, count_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               err_resp_reg, err_resp_next;
    logic [15:0]        err_count_reg, err_count_next;
    logic [31:0]        err_addr_reg, err_addr_next;

    logic [NUM_REGIONS-1:0] match;
    logic [3:0]             lat_tab [NUM_REGIONS];
    logic [31:0]            rd_data [NUM_REGIONS];
    logic                   hit;
    logic [IDX_W-1:0]       hit_idx;
    logic [3:0]             hit_lat;
    logic                   ready;
    logic                   accept;
    logic                   is_write;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
            assign match[gi]   = (req_addr_i & REGION_MASK[gi*32 +: 32]) == REGION_BASE[gi*32 +: 32];
            // A configured latency of zero behaves exactly like one.
            assign lat_tab[gi] = (REGION_LATENCY[gi*4 +: 4] == 4'd0) ? 4'd1 : REGION_LATENCY[gi*4 +: 4];
            assign rd_data[gi] = dev_read_data_i[gi*32 +: 32];
            assign dev_sel_o[gi] = accept && hit && (hit_idx == IDX_W'(gi));
            assign dev_write_mask_o[gi*4 +: 4] = dev_sel_o[gi] ? req_write_mask_i : 4'b0000;
        end
    endgenerate

    // Lowest-index match wins: scan downwards so the last assignment is the lowest index.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign hit_lat  = lat_tab[hit_idx];
    assign is_write = |req_write_mask_i;
    assign ready    = !reset_i && ((state_reg == S_IDLE) || (state_reg == S_RESP));
    assign accept   = req_valid_i && ready;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg     <= S_IDLE;
            count_reg     <= 4'd0;
            idx_reg       <= '0;
            err_resp_reg  <= 1'b0;
            err_count_reg <= 16'd0;
            err_addr_reg  <= 32'd0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            idx_reg       <= idx_next;
            err_resp_reg  <= err_resp_next;
            err_count_reg <= err_count_next;
            err_addr_reg  <= err_addr_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        idx_next       = idx_reg;
        err_resp_next  = err_resp_reg;
        err_count_next = err_count_reg;
        err_addr_next  = err_addr_reg;

        case (state_reg)
            S_WAIT: begin
                count_next = count_reg - 4'd1;
                if (count_reg <= 4'd1) begin
                    state_next = S_RESP;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        // Acceptance only happens in IDLE or RESP, so it overrides the defaults above.
        if (accept && !is_write) begin
            idx_next      = hit_idx;
            err_resp_next = !hit;
            if (hit && (hit_lat > 4'd1)) begin
                state_next = S_WAIT;
                count_next = hit_lat - 4'd1;
            end else begin
                state_next = S_RESP;
                count_next = 4'd0;
            end
        end

        if (accept && !hit) begin
            err_addr_next = req_addr_i;
            if (err_count_reg != 16'hFFFF) begin
                err_count_next = err_count_reg + 16'd1;
            end
        end
    end

    always_comb begin
        req_ready_o      = ready;
        dev_addr_o       = req_addr_i;
        dev_write_data_o = req_write_data_i;
        resp_valid_o     = !reset_i && (state_reg == S_RESP);
        resp_err_o       = resp_valid_o && err_resp_reg;
        resp_data_o      = (resp_valid_o && !err_resp_reg) ? rd_data[idx_reg] : 32'd0;
        err_count_o      = reset_i ? 16'd0 : err_count_reg;
        err_addr_o       = reset_i ? 32'd0 : err_addr_reg;
    end

endmodule
